operand_demux_loader: RTL and testbench
=======================================

# operand_demux_loader

Sequential 1-to-2 operand distributor for the sequential multiplier datapath. Accepts operand nibbles one at a time on a shared WIDTH-bit input bus, steers the first into the A register and the second into the B register, then presents the captured pair to the multiplier with a valid/ready handshake. Sits between the operand source and the multiplier operand inputs, inverting the 2:1 operand selection done downstream.

## Interface
- WIDTH, 4, operand width in bits (in_data, out_a, out_b)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; discards any partial or held pair
- in_valid  input  1  in_data carries an operand this cycle
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  WIDTH  operand nibble (A first, then B)
- next_slot  output  1  0 = next accepted operand goes to A, 1 = goes to B
- out_valid  output  1  out_a/out_b hold a complete pair
- out_ready  input  1  multiplier accepts the pair
- out_a  output  WIDTH  registered operand A
- out_b  output  WIDTH  registered operand B
- pair_cnt  output  8  count of pairs delivered, wraps 255 -> 0

## Operation
- States: LOAD_A, LOAD_B, HOLD. Reset state LOAD_A.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- LOAD_A: in_ready=1, next_slot=0. On input transfer: out_a <= in_data, go LOAD_B.
- LOAD_B: in_ready=1, next_slot=1. On input transfer: out_b <= in_data, go HOLD.
- HOLD: in_ready=0, out_valid=1, next_slot=0. out_a/out_b stable. On output transfer: pair_cnt <= pair_cnt+1 (mod 256), go LOAD_A.
- out_valid=1 only in HOLD; in_ready=1 only in LOAD_A/LOAD_B. Both decoded from registered state (no combinational in->out path).
- in_valid ignored in HOLD; out_ready ignored outside HOLD.
- flush (any state): next state LOAD_A; out_a/out_b keep contents (don't-care, not valid). flush has priority over any simultaneous transfer: an input accepted the same cycle is dropped, an output handshake in HOLD is not counted (pair_cnt unchanged), although out_valid was high that cycle — the consumer must not use a pair presented while flush=1.
- in_valid deasserted mid-pair: block waits indefinitely in LOAD_B with A retained.

## Timing
- Reset (rst_n=0, async): state=LOAD_A, out_a=0, out_b=0, pair_cnt=0, in_ready=1, out_valid=0, next_slot=0. Reset mid-pair discards the partial pair.
- Minimum latency: A accepted cycle n, B accepted n+1, out_valid=1 from cycle n+2.
- Max throughput: one pair per 3 cycles (A, B, output handshake); no overlap of HOLD with new input.
- out_ready held high in HOLD: pair consumed the first HOLD cycle; LOAD_A next cycle.
- All outputs registered or decoded from registered state; changes only on rising clk or rst_n assertion.

## Test plan
- Reset then in_data=3 (valid), in_data=5 (valid), out_ready=1 -> out_valid high 1 cycle with out_a=3, out_b=5; pair_cnt=1; back to LOAD_A.
- A=0xF accepted, in_valid low 4 cycles, then B=0x2 -> stays LOAD_B, next_slot=1 throughout gap; pair out_a=F, out_b=2.
- Pair A=7,B=9 with out_ready=0 for 5 cycles, in_valid=1 with data=0xC -> in_ready=0, out_a/out_b stay 7/9, no capture of 0xC; out_ready=1 -> pair_cnt increments once.
- flush asserted in LOAD_B after A=4 -> LOAD_A next cycle, next_slot=0; following A=1,B=2 yields pair 1/2.
- flush=1 and out_ready=1 in HOLD same cycle -> pair_cnt unchanged, state LOAD_A.
- 256 back-to-back pairs -> pair_cnt wraps to 0; async rst_n pulse mid-LOAD_B -> all outputs reset values immediately.

Source files
------------

// File: rtl/operand_demux_loader.sv
// ---------------------------------------------------------------------------
// operand_demux_loader : steers alternate operands into A/B, presents pair
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_demux_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             next_slot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [7:0]       pair_cnt
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [7:0]       pair_cnt_q, pair_cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  // Handshake outputs come only from the state register, never from inputs.
  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == HOLD);
  assign next_slot = (state_q == LOAD_B);
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign pair_cnt  = pair_cnt_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    pair_cnt_d = pair_cnt_q;
    if (flush) begin
      // Abort wins over any same-cycle transfer; register contents are stale.
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (in_xfer) begin
            out_a_d = in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            out_b_d = in_data;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_xfer) begin
            pair_cnt_d = pair_cnt_q + 8'd1;
            state_d    = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      out_a_q    <= '0;
      out_b_q    <= '0;
      pair_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_demux_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_demux_loader : scoreboard bench for operand_demux_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_operand_demux_loader;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             next_slot;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [7:0]       pair_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [2*WIDTH-1:0] sb_q[$];

  operand_demux_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .next_slot (next_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every counted output handshake must match the oldest pushed pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      logic [2*WIDTH-1:0] e;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: pair a=%h b=%h delivered, none expected", out_a, out_b);
      end else begin
        e = sb_q.pop_front();
        if ({out_a, out_b} !== e) begin
          miscompares++;
          $display("FAIL sb_pair: got a=%h b=%h, expected a=%h b=%h",
                   out_a, out_b, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  // Caller is positioned just after a rising edge; returns likewise.
  task automatic send_op(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take_pair();
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL take_timeout: out_valid=%b after %0d cycles, expected 1", out_valid, n);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, next_slot, out_a, out_b, pair_cnt} !== {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b slot=%b a=%h b=%h cnt=%0d, expected 1 0 0 0 0 0",
               in_ready, out_valid, next_slot, out_a, out_b, pair_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sb_q.push_back({4'h3, 4'h5});
    send_op(4'h3);
    @(negedge clk);
    vectors++;
    if (next_slot !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_slot_b: next_slot=%b, expected 1", next_slot);
    end
    @(posedge clk); #1;
    send_op(4'h5);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    take_pair();
    @(negedge clk);
    vectors++;
    if (pair_cnt !== exp_cnt || exp_cnt !== 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1 || next_slot !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after: cnt=%0d vld=%b rdy=%b slot=%b, expected cnt=1 vld=0 rdy=1 slot=0",
               pair_cnt, out_valid, in_ready, next_slot);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gap();
    sb_q.push_back({4'hF, 4'h2});
    send_op(4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (next_slot !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_a !== 4'hF) begin
        miscompares++;
        $display("FAIL gap_wait[%0d]: slot=%b rdy=%b vld=%b a=%h, expected 1 1 0 F",
                 i, next_slot, in_ready, out_valid, out_a);
      end
      @(posedge clk); #1;
    end
    send_op(4'h2);
    take_pair();
  endtask

  task automatic test_hold();
    sb_q.push_back({4'h7, 4'h9});
    send_op(4'h7);
    send_op(4'h9);
    in_valid = 1'b1;
    in_data  = 4'hC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 4'h7 || out_b !== 4'h9) begin
        miscompares++;
        $display("FAIL hold_stall[%0d]: rdy=%b vld=%b a=%h b=%h, expected 0 1 7 9",
                 i, in_ready, out_valid, out_a, out_b);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take_pair();
    @(negedge clk);
    vectors++;
    if (pair_cnt !== exp_cnt || exp_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL hold_count: pair_cnt=%0d, expected 3", pair_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_load_b();
    send_op(4'h4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (next_slot !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lb: slot=%b rdy=%b vld=%b, expected 0 1 0", next_slot, in_ready, out_valid);
    end
    @(posedge clk); #1;
    sb_q.push_back({4'h1, 4'h2});
    send_op(4'h1);
    send_op(4'h2);
    take_pair();
  endtask

  task automatic test_flush_hold();
    send_op(4'h6);
    send_op(4'h8);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (pair_cnt !== exp_cnt || exp_cnt !== 8'd4 || out_valid !== 1'b0 || next_slot !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hold: cnt=%0d vld=%b slot=%b rdy=%b, expected cnt=4 0 0 1",
               pair_cnt, out_valid, next_slot, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int npairs;
    logic [WIDTH-1:0] a, b;
    npairs = 256 - int'(exp_cnt);
    for (int i = 0; i < npairs; i++) begin
      a = WIDTH'($urandom_range(0, 15));
      b = WIDTH'($urandom_range(0, 15));
      sb_q.push_back({a, b});
      send_op(a);
      send_op(b);
      take_pair();
      if (i == npairs - 2) begin
        @(negedge clk);
        vectors++;
        if (pair_cnt !== 8'd255) begin
          miscompares++;
          $display("FAIL b2b_255: pair_cnt=%0d, expected 255", pair_cnt);
        end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    vectors++;
    if (pair_cnt !== 8'd0 || exp_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_wrap: pair_cnt=%0d, expected 0", pair_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    sb_q.push_back({4'hA, 4'hB});
    send_op(4'hA);
    send_op(4'hB);
    take_pair();
    send_op(4'hD);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    vectors++;
    if ({in_ready, out_valid, next_slot, out_a, out_b, pair_cnt} !== {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00}) begin
      miscompares++;
      $display("FAIL async_reset: rdy=%b vld=%b slot=%b a=%h b=%h cnt=%0d, expected 1 0 0 0 0 0",
               in_ready, out_valid, next_slot, out_a, out_b, pair_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.push_back({4'hE, 4'h1});
    send_op(4'hE);
    send_op(4'h1);
    take_pair();
    @(negedge clk);
    vectors++;
    if (pair_cnt !== 8'd1 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset: pair_cnt=%0d pending=%0d, expected 1 0", pair_cnt, sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gap();
    test_hold();
    test_flush_load_b();
    test_flush_hold();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
